// File: rtl/gates_mux_bist_pkg.sv
// Shared types and constants for the gates_mux built-in self-test slice.
package gates_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int RES_W    = 7;
  localparam int RES_AND  = 0;
  localparam int RES_OR   = 1;
  localparam int RES_NOT  = 2;
  localparam int RES_NAND = 3;
  localparam int RES_NOR  = 4;
  localparam int RES_XOR  = 5;
  localparam int RES_XNOR = 6;

  localparam int NUM_VEC  = 4;

endpackage

// File: rtl/gates_mux_bist_expect.sv
// Reference truth table for gates_mux: maps an operand pair to the seven gate outputs.
module gates_expect
  import gates_bist_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] exp_vec
);

  always_comb begin
    exp_vec           = '0;
    exp_vec[RES_AND]  = a & b;
    exp_vec[RES_OR]   = a | b;
    exp_vec[RES_NOT]  = ~a;
    exp_vec[RES_NAND] = ~(a & b);
    exp_vec[RES_NOR]  = ~(a | b);
    exp_vec[RES_XOR]  = a ^ b;
    exp_vec[RES_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gates_mux_bist.sv
// BIST controller for gates_mux: walks all four operand pairs, checks results, reports.
// Optional continuous looping is enabled by defining GATES_BIST_LOOP_EN.
module gates_mux_bist
  import gates_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef GATES_BIST_LOOP_EN
  input  logic             loop_i,
`endif
  output logic             a_o,
  output logic             b_o,
  input  logic [RES_W-1:0] res_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       fail_vec,
  output logic [RES_W-1:0] fail_mask
);

  localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [1:0]       LAST_IDX    = 2'(NUM_VEC - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [RES_W-1:0] exp_vec;
  logic [RES_W-1:0] mismatch;
  logic [ERR_W-1:0] err_next;
  logic             loop_en;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  gates_expect u_expect (
    .a       (a_o),
    .b       (b_o),
    .exp_vec (exp_vec)
  );

  assign mismatch = res_i ^ exp_vec;
  assign err_next = (|mismatch) ? sat_inc(err_cnt) : err_cnt;

`ifdef GATES_BIST_LOOP_EN
  assign loop_en = loop_i;
`else
  assign loop_en = 1'b0;
`endif

  // Operands are loaded on entry to DRIVE so they stay stable through SETTLE and CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      a_o        <= 1'b0;
      b_o        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_mask  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            idx       <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_vec  <= '0;
            fail_mask <= '0;
          end
        end
        S_DRIVE: begin
          done       <= 1'b0;
          pass       <= 1'b0;
          settle_cnt <= '0;
          state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          err_cnt <= err_next;
          // A zero count means nothing has failed yet since the last start.
          if ((|mismatch) && (err_cnt == '0)) begin
            fail_vec  <= {a_o, b_o};
            fail_mask <= mismatch;
          end
          if (idx == LAST_IDX) begin
            done <= 1'b1;
            pass <= (err_next == '0);
            if (loop_en) begin
              state <= S_DRIVE;
              idx   <= '0;
              a_o   <= 1'b0;
              b_o   <= 1'b0;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
            end
          end else begin
            idx        <= idx + 2'd1;
            {a_o, b_o} <= idx + 2'd1;
            state      <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
